// File: rtl/munoc_link_monitor_mc_pkg.sv
// Shared definitions for the multi-channel MUNOC link monitor: default
// parameter values, window-counter width helper and output field offsets.
// Optional feature macro: MUNOC_LINK_MONITOR_MAX_STALL_EN.
package munoc_link_monitor_mc_pkg;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_BW_STALL_CNT  = 16;
  localparam int DEF_TIMEOUT_LIMIT = 100;
  localparam int DEF_BW_XFER_CNT   = 16;
  localparam int DEF_WINDOW_CYCLES = 1024;

  // Bits needed to hold 0..value-1, never less than 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  // LSB position of channel ch inside a packed per-channel output bus.
  function automatic int fld_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/munoc_link_monitor_mc_if.sv
// Bundle of the observed valid/ready pairs. The traffic side drives them
// (master); the monitor only ever listens (slave).
interface munoc_link_monitor_mc_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;

  modport master (output ch_valid, output ch_ready);
  modport slave  (input  ch_valid, input  ch_ready);
endinterface

// File: rtl/munoc_link_monitor_mc_channel.sv
// One monitored channel: consecutive-stall counter, sticky timeout flag,
// windowed transfer accumulator and, when MUNOC_LINK_MONITOR_MAX_STALL_EN
// is defined, the longest stall run seen in the window.
module munoc_link_monitor_mc_channel
  import munoc_link_monitor_mc_pkg::*;
#(
  parameter int BW_STALL_CNT  = DEF_BW_STALL_CNT,
  parameter int TIMEOUT_LIMIT = DEF_TIMEOUT_LIMIT,
  parameter int BW_XFER_CNT   = DEF_BW_XFER_CNT
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic                    ready_i,
  input  logic                    window_close_i,
  output logic                    timeout_o,
  output logic [BW_XFER_CNT-1:0]  xfer_count_o,
  output logic [BW_STALL_CNT-1:0] max_stall_o
);

  localparam logic [BW_STALL_CNT-1:0] STALL_MAX = '1;
  localparam logic [BW_STALL_CNT-1:0] TO_CMP    = BW_STALL_CNT'(TIMEOUT_LIMIT - 1);
  localparam logic [BW_XFER_CNT-1:0]  XFER_MAX  = '1;

  logic                    stall, xfer;
  logic [BW_STALL_CNT-1:0] stall_q, stall_d;
  logic                    timeout_q, timeout_d;
  logic [BW_XFER_CNT-1:0]  acc_q, acc_d, acc_inc;
  logic [BW_XFER_CNT-1:0]  xfer_cnt_q, xfer_cnt_d;

  assign stall = valid_i & ~ready_i;
  assign xfer  = valid_i &  ready_i;

  // Next-state for stall run, timeout and transfer accumulation; the
  // accumulator already includes this cycle's transfer when the window closes.
  always_comb begin
    stall_d    = stall_q;
    timeout_d  = timeout_q;
    acc_d      = acc_q;
    xfer_cnt_d = xfer_cnt_q;
    acc_inc    = (xfer && (acc_q != XFER_MAX)) ? acc_q + BW_XFER_CNT'(1) : acc_q;
    if (enable_i) begin
      if (stall) begin
        stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + BW_STALL_CNT'(1);
      end else begin
        stall_d = '0;
      end
      if (stall && (stall_q == TO_CMP)) timeout_d = 1'b1;
      if (window_close_i) begin
        xfer_cnt_d = acc_inc;
        acc_d      = '0;
      end else begin
        acc_d      = acc_inc;
      end
    end
  end

  // Channel state registers; clear outranks every same-cycle event.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      stall_q    <= '0;
      timeout_q  <= 1'b0;
      acc_q      <= '0;
      xfer_cnt_q <= '0;
    end else if (clear_i) begin
      stall_q    <= '0;
      timeout_q  <= 1'b0;
      acc_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
      acc_q      <= acc_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign timeout_o    = timeout_q;
  assign xfer_count_o = xfer_cnt_q;

`ifdef MUNOC_LINK_MONITOR_MAX_STALL_EN
  logic [BW_STALL_CNT-1:0] run_max_q, run_max_d, peak;
  logic [BW_STALL_CNT-1:0] max_q, max_d;

  // Track the longest run; an open run keeps counting into the next window.
  always_comb begin
    peak      = (stall_d > run_max_q) ? stall_d : run_max_q;
    run_max_d = run_max_q;
    max_d     = max_q;
    if (enable_i) begin
      if (window_close_i) begin
        max_d     = peak;
        run_max_d = '0;
      end else begin
        run_max_d = peak;
      end
    end
  end

  // Max-stall registers.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      run_max_q <= '0;
      max_q     <= '0;
    end else if (clear_i) begin
      run_max_q <= '0;
      max_q     <= '0;
    end else begin
      run_max_q <= run_max_d;
      max_q     <= max_d;
    end
  end

  assign max_stall_o = max_q;
`else
  assign max_stall_o = '0;
`endif

endmodule

// File: rtl/munoc_link_monitor_mc.sv
// Passive multi-channel valid/ready monitor: per-channel sticky stall
// timeouts and per-window transfer counts for the debug/status block.
// Optional feature macro: MUNOC_LINK_MONITOR_MAX_STALL_EN (longest stall
// run per window on max_stall; tied to 0 when undefined).
module munoc_link_monitor_mc
  import munoc_link_monitor_mc_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int BW_STALL_CNT  = DEF_BW_STALL_CNT,
  parameter int TIMEOUT_LIMIT = DEF_TIMEOUT_LIMIT,
  parameter int BW_XFER_CNT   = DEF_BW_XFER_CNT,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           mon_enable,
  input  logic                           mon_clear,
  munoc_link_monitor_mc_if.slave         mon_if,
  output logic [NUM_CH-1:0]              timeout_flag,
  output logic                           timeout_any,
  output logic                           window_done,
  output logic [NUM_CH*BW_XFER_CNT-1:0]  xfer_count,
  output logic [NUM_CH*BW_STALL_CNT-1:0] max_stall
);

  localparam int               WIN_W    = clog2_f(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic [WIN_W-1:0] win_q, win_d;
  logic             done_q;
  logic             window_close;

  assign window_close = mon_enable & (win_q == WIN_LAST);

  // Window position advances only on enabled cycles and wraps at the last slot.
  always_comb begin
    win_d = win_q;
    if (mon_enable) begin
      win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
    end
  end

  // Window position and the one-cycle close pulse.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      win_q  <= '0;
      done_q <= 1'b0;
    end else if (mon_clear) begin
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      done_q <= window_close;
    end
  end

  assign window_done = done_q;
  assign timeout_any = |timeout_flag;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    munoc_link_monitor_mc_channel #(
      .BW_STALL_CNT  (BW_STALL_CNT),
      .TIMEOUT_LIMIT (TIMEOUT_LIMIT),
      .BW_XFER_CNT   (BW_XFER_CNT)
    ) u_ch (
      .clk            (clk),
      .rstnn          (rstnn),
      .enable_i       (mon_enable),
      .clear_i        (mon_clear),
      .valid_i        (mon_if.ch_valid[g]),
      .ready_i        (mon_if.ch_ready[g]),
      .window_close_i (window_close),
      .timeout_o      (timeout_flag[g]),
      .xfer_count_o   (xfer_count[fld_lsb(g, BW_XFER_CNT) +: BW_XFER_CNT]),
      .max_stall_o    (max_stall[fld_lsb(g, BW_STALL_CNT) +: BW_STALL_CNT])
    );
  end

endmodule

// File: tb/tb_munoc_link_monitor_mc.sv
// Directed bench for munoc_link_monitor_mc. Instance A (4 channels, 16-cycle
// window) is tracked by a reference model whose closed-window transfer counts
// go to a scoreboard queue, popped when window_done pulses. Instance B
// (4-bit transfer counter, 32-cycle window) covers saturation.
module tb_munoc_link_monitor_mc;

  logic clk;
  logic rstnn;
  logic mon_enable;
  logic mon_clear;
  logic en_b;
  logic clr_b;

  munoc_link_monitor_mc_if #(.NUM_CH(4)) if_a ();
  munoc_link_monitor_mc_if #(.NUM_CH(1)) if_b ();

  logic [3:0]  timeout_a;
  logic        any_a;
  logic        done_a;
  logic [63:0] xfer_a;
  logic [63:0] max_a;

  logic [0:0]  timeout_b;
  logic        any_b;
  logic        done_b;
  logic [3:0]  xfer_b;
  logic [15:0] max_b;

  munoc_link_monitor_mc #(
    .NUM_CH(4), .BW_STALL_CNT(16), .TIMEOUT_LIMIT(100),
    .BW_XFER_CNT(16), .WINDOW_CYCLES(16)
  ) dut_a (
    .clk          (clk),
    .rstnn        (rstnn),
    .mon_enable   (mon_enable),
    .mon_clear    (mon_clear),
    .mon_if       (if_a.slave),
    .timeout_flag (timeout_a),
    .timeout_any  (any_a),
    .window_done  (done_a),
    .xfer_count   (xfer_a),
    .max_stall    (max_a)
  );

  munoc_link_monitor_mc #(
    .NUM_CH(1), .BW_STALL_CNT(16), .TIMEOUT_LIMIT(100),
    .BW_XFER_CNT(4), .WINDOW_CYCLES(32)
  ) dut_b (
    .clk          (clk),
    .rstnn        (rstnn),
    .mon_enable   (en_b),
    .mon_clear    (clr_b),
    .mon_if       (if_b.slave),
    .timeout_flag (timeout_b),
    .timeout_any  (any_b),
    .window_done  (done_b),
    .xfer_count   (xfer_b),
    .max_stall    (max_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model for instance A
  int          m_stall [4];
  int          m_acc   [4];
  logic [3:0]  m_to;
  int          m_win;
  logic        m_close;
  logic [63:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_stall[c] = 0;
      m_acc[c]   = 0;
    end
    m_to  = '0;
    m_win = 0;
  endtask

  // One clock: update the model with inputs seen at the edge, then check A.
  task automatic tick();
    logic [63:0] exp_x;
    logic        s, x;
    @(posedge clk);
    m_close = 1'b0;
    exp_x   = '0;
    if (!rstnn || mon_clear) begin
      model_reset();
    end else if (mon_enable) begin
      m_close = (m_win == 15);
      for (int c = 0; c < 4; c++) begin
        s = if_a.ch_valid[c] & ~if_a.ch_ready[c];
        x = if_a.ch_valid[c] &  if_a.ch_ready[c];
        if (s && m_stall[c] == 99) m_to[c] = 1'b1;
        if (s) m_stall[c] = (m_stall[c] == 65535) ? 65535 : m_stall[c] + 1;
        else   m_stall[c] = 0;
        if (x && m_acc[c] < 65535) m_acc[c]++;
        exp_x[c*16 +: 16] = 16'(m_acc[c]);
        if (m_close) m_acc[c] = 0;
      end
      if (m_close) sb_q.push_back(exp_x);
      m_win = (m_win + 1) % 16;
    end
    #1;
    chk("window_done", {63'd0, done_a}, {63'd0, m_close});
    chk("timeout_flag", {60'd0, timeout_a}, {60'd0, m_to});
    chk("timeout_any", {63'd0, any_a}, {63'd0, |m_to});
    if (done_a === 1'b1) begin
      chk("sb_has_entry", {63'd0, (sb_q.size() != 0)}, 64'd1);
      if (sb_q.size() != 0) chk("xfer_count", xfer_a, sb_q.pop_front());
    end
  endtask

  // Advance until A closes a window, bounded.
  task automatic wait_done_a(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (done_a === 1'b1) seen = 1'b1;
    end
    chk(tag, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b_seen;
    rstnn       = 1'b0;
    mon_enable  = 1'b0;
    mon_clear   = 1'b0;
    en_b        = 1'b1;
    clr_b       = 1'b0;
    if_a.ch_valid = '0;
    if_a.ch_ready = '0;
    if_b.ch_valid = 1'b1;
    if_b.ch_ready = 1'b1;
    model_reset();

    // reset state
    tick();
    tick();
    chk("rst_timeout", {60'd0, timeout_a}, 64'd0);
    chk("rst_xfer", xfer_a, 64'd0);
    chk("rst_max", max_a, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    rstnn      = 1'b1;
    mon_enable = 1'b1;

    // ch0 stalls 99 then completes, ch1 stalls 100, ch2 streams, ch3 idle
    if_a.ch_valid = 4'b0111;
    if_a.ch_ready = 4'b0100;
    repeat (99) tick();
    chk("to_after_99", {60'd0, timeout_a}, 64'd0);
    if_a.ch_ready = 4'b0101;
    tick();
    chk("to_ch1_at_100", {60'd0, timeout_a}, 64'h2);
    chk("to_any_set", {63'd0, any_a}, 64'd1);
    if_a.ch_valid = 4'b0110;
    if_a.ch_ready = 4'b0110;
    repeat (20) tick();
    chk("to_ch1_sticky", {60'd0, timeout_a}, 64'h2);
    wait_done_a("wait_win_ch2");
    chk("ch2_full_window", {48'd0, xfer_a[32 +: 16]}, 64'd16);

    // B: continuous transfers in 32-cycle window saturate a 4-bit count
    b_seen = 1'b0;
    for (int k = 0; k < 80 && !b_seen; k++) begin
      tick();
      if (done_b === 1'b1) b_seen = 1'b1;
    end
    chk("b_window_seen", {63'd0, b_seen}, 64'd1);
    chk("b_xfer_sat", {60'd0, xfer_b}, 64'd15);

    // mon_clear drops sticky flags and counts
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
    chk("clr_timeout", {60'd0, timeout_a}, 64'd0);
    chk("clr_xfer", xfer_a, 64'd0);

    // ch3 stall with a 10-cycle enable gap shifts the timeout by 10
    if_a.ch_valid = 4'b1000;
    if_a.ch_ready = 4'b0000;
    repeat (50) tick();
    mon_enable = 1'b0;
    repeat (10) tick();
    mon_enable = 1'b1;
    repeat (49) tick();
    chk("gap_to_not_yet", {60'd0, timeout_a}, 64'd0);
    tick();
    chk("gap_to_set", {60'd0, timeout_a}, 64'h8);

    // stall runs of 3 and 7 within one fresh window
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
    if_a.ch_valid = 4'b0001;
    if_a.ch_ready = 4'b0000;
    repeat (3) tick();
    if_a.ch_ready = 4'b0001;
    tick();
    if_a.ch_ready = 4'b0000;
    repeat (7) tick();
    if_a.ch_ready = 4'b0001;
    tick();
    if_a.ch_valid = 4'b0000;
    wait_done_a("wait_win_max");
    chk("ch0_two_xfers", {48'd0, xfer_a[15:0]}, 64'd2);
`ifdef MUNOC_LINK_MONITOR_MAX_STALL_EN
    chk("max_stall", max_a, 64'd7);
`else
    chk("max_stall_off", max_a, 64'd0);
`endif

    // mid-window clear
    if_a.ch_valid = 4'b0100;
    if_a.ch_ready = 4'b0100;
    repeat (5) tick();
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
    chk("midclr_xfer", xfer_a, 64'd0);
    chk("midclr_max", max_a, 64'd0);
    chk("midclr_done", {63'd0, done_a}, 64'd0);

    // mid-window async reset after a closed window
    wait_done_a("wait_win_pre_rst");
    repeat (6) tick();
    #2;
    rstnn = 1'b0;
    #1;
    chk("arst_xfer", xfer_a, 64'd0);
    chk("arst_max", max_a, 64'd0);
    chk("arst_timeout", {60'd0, timeout_a}, 64'd0);
    chk("arst_xfer_b", {60'd0, xfer_b}, 64'd0);
    tick();
    rstnn = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
